// File: rtl/cga_mac_pkg.sv
// Shared types for the CGA MAC address-path blocks: request FSM encoding and ring constants.
package cga_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [1:0] RING3 = 2'd3;

endpackage

// File: rtl/cga_mac_ptsel_gen_if.sv
// Request/response bundle between the microcode request logic and the PT select generator.
interface cga_mac_ptsel_gen_if #(
  parameter int LA_W   = 16,
  parameter int NUM_PT = 4,
  parameter int PT_W   = 2,
  parameter int CNT_W  = 8
);
  logic              CSMREQ;
  logic [LA_W-1:0]   LA;
  logic [PT_W-1:0]   PCR_PT;
  logic [PT_W-1:0]   PCR_APT;
  logic [1:0]        PCR_RING;
  logic              SELPT;
  logic              EXM;
  logic              PONI;
  logic              PEX;
  logic              SEGZ;
  logic              CLR_CNT;
  logic              ACK;
  logic              BUSY;
  logic [NUM_PT-1:0] PT_SEL;
  logic              SHADOW;
  logic              LSHADOW;
  logic              PHYS;
  logic              PTERR;
  logic [CNT_W-1:0]  SHCNT;

  modport master (
    output CSMREQ, LA, PCR_PT, PCR_APT, PCR_RING, SELPT, EXM, PONI, PEX, SEGZ, CLR_CNT,
    input  ACK, BUSY, PT_SEL, SHADOW, LSHADOW, PHYS, PTERR, SHCNT
  );

  modport slave (
    input  CSMREQ, LA, PCR_PT, PCR_APT, PCR_RING, SELPT, EXM, PONI, PEX, SEGZ, CLR_CNT,
    output ACK, BUSY, PT_SEL, SHADOW, LSHADOW, PHYS, PTERR, SHCNT
  );
endinterface

// File: rtl/cga_mac_shadow_det.sv
// Combinational shadow-window hit decode for a captured logical address and mode bits.
module cga_mac_shadow_det
  import cga_mac_pkg::*;
#(
  parameter int              LA_W         = 16,
  parameter logic [LA_W-1:0] SHADOW_MASK  = 16'hFE00,
  parameter logic [LA_W-1:0] SHADOW_MATCH = 16'hFE00
) (
  input  logic [LA_W-1:0] la,
  input  logic [1:0]      ring,
  input  logic            poni,
  input  logic            pex,
  input  logic            segz,
  output logic            hit
);

  logic win_hit, mode_ok;

  assign win_hit = (la & SHADOW_MASK) == SHADOW_MATCH;
  // Shadow is reachable from ring 3, with paging off, or in PEX; PEX additionally needs segment zero.
  assign mode_ok = ((ring == RING3) || !poni || pex) && (!pex || segz);
  assign hit     = win_hit && mode_ok;

endmodule

// File: rtl/cga_mac_ptsel_gen.sv
// Page-table / shadow-window selector: captures a CPU request, decodes it, and returns a registered
// one-hot PT select with a one-cycle ACK, plus a saturating shadow-hit counter.
module cga_mac_ptsel_gen
  import cga_mac_pkg::*;
#(
  parameter int              LA_W         = 16,
  parameter int              NUM_PT       = 4,
  parameter int              PT_W         = 2,
  parameter logic [LA_W-1:0] SHADOW_MASK  = 16'hFE00,
  parameter logic [LA_W-1:0] SHADOW_MATCH = 16'hFE00,
  parameter int              EXM_PT       = 0,
  parameter int              CNT_W        = 8
) (
  input logic                 MCLK,
  input logic                 RESET,
  cga_mac_ptsel_gen_if.slave  bus
);

  state_t state;

  logic [LA_W-1:0]   c_la;
  logic [PT_W-1:0]   c_pt, c_apt;
  logic [1:0]        c_ring;
  logic              c_selpt, c_exm, c_poni, c_pex, c_segz;

  logic              dec_shadow, dec_phys, dec_pterr;
  logic [NUM_PT-1:0] dec_sel;

  logic              d_shadow, d_phys, d_pterr, hit;
  logic [NUM_PT-1:0] d_sel;
  logic [PT_W-1:0]   idx;

  cga_mac_shadow_det #(
    .LA_W         (LA_W),
    .SHADOW_MASK  (SHADOW_MASK),
    .SHADOW_MATCH (SHADOW_MATCH)
  ) u_shadow_det (
    .la   (c_la),
    .ring (c_ring),
    .poni (c_poni),
    .pex  (c_pex),
    .segz (c_segz),
    .hit  (hit)
  );

  // Priority: shadow, then paging off, then PT index range check.
  always_comb begin
    d_shadow = 1'b0;
    d_phys   = 1'b0;
    d_pterr  = 1'b0;
    d_sel    = '0;
    idx      = c_exm ? PT_W'(EXM_PT) : (c_selpt ? c_apt : c_pt);
    if (hit)                       d_shadow = 1'b1;
    else if (!c_poni)              d_phys   = 1'b1;
    else if (int'(idx) >= NUM_PT)  d_pterr  = 1'b1;
    else                           d_sel    = NUM_PT'(1) << idx;
  end

  assign bus.BUSY = (state != ST_IDLE);

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      c_la        <= '0;
      c_pt        <= '0;
      c_apt       <= '0;
      c_ring      <= '0;
      c_selpt     <= 1'b0;
      c_exm       <= 1'b0;
      c_poni      <= 1'b0;
      c_pex       <= 1'b0;
      c_segz      <= 1'b0;
      dec_shadow  <= 1'b0;
      dec_phys    <= 1'b0;
      dec_pterr   <= 1'b0;
      dec_sel     <= '0;
      bus.ACK     <= 1'b0;
      bus.PT_SEL  <= '0;
      bus.SHADOW  <= 1'b0;
      bus.LSHADOW <= 1'b0;
      bus.PHYS    <= 1'b0;
      bus.PTERR   <= 1'b0;
      bus.SHCNT   <= '0;
    end else begin
      bus.ACK <= 1'b0;
      case (state)
        ST_IDLE: if (bus.CSMREQ) begin
          c_la    <= bus.LA;
          c_pt    <= bus.PCR_PT;
          c_apt   <= bus.PCR_APT;
          c_ring  <= bus.PCR_RING;
          c_selpt <= bus.SELPT;
          c_exm   <= bus.EXM;
          c_poni  <= bus.PONI;
          c_pex   <= bus.PEX;
          c_segz  <= bus.SEGZ;
          state   <= ST_CAPT;
        end
        ST_CAPT: begin
          dec_shadow <= d_shadow;
          dec_phys   <= d_phys;
          dec_pterr  <= d_pterr;
          dec_sel    <= d_sel;
          state      <= ST_DRIVE;
        end
        ST_DRIVE: begin
          bus.ACK     <= 1'b1;
          bus.PT_SEL  <= dec_sel;
          bus.SHADOW  <= dec_shadow;
          bus.PHYS    <= dec_phys;
          bus.PTERR   <= dec_pterr;
          bus.LSHADOW <= bus.SHADOW;
          state       <= bus.CSMREQ ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT: if (!bus.CSMREQ) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Clear takes precedence over a same-cycle hit.
      if (bus.CLR_CNT)
        bus.SHCNT <= '0;
      else if (state == ST_DRIVE && dec_shadow && bus.SHCNT != {CNT_W{1'b1}})
        bus.SHCNT <= bus.SHCNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_cga_mac_ptsel_gen.sv
// Randomised and directed bench for cga_mac_ptsel_gen with a request-level reference model.
module tb_cga_mac_ptsel_gen;

  localparam int CNT_W  = 2;
  localparam int NUM_PT = 4;

  logic MCLK = 1'b0;
  logic RESET;
  int   n_chk = 0;
  int   n_fail = 0;

  // model state
  logic        m_prev_shadow = 1'b0;
  int          m_cnt = 0;

  cga_mac_ptsel_gen_if #(.LA_W(16), .NUM_PT(NUM_PT), .PT_W(2), .CNT_W(CNT_W)) bus ();

  cga_mac_ptsel_gen #(.LA_W(16), .NUM_PT(NUM_PT), .PT_W(2), .SHADOW_MASK(16'hFE00),
                      .SHADOW_MATCH(16'hFE00), .EXM_PT(0), .CNT_W(CNT_W)) dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 MCLK = ~MCLK;

  // Reference result of one request: {shadow, phys, pterr, pt_sel}
  function automatic logic [6:0] model_decode(input logic [15:0] la, input int pt, input int apt,
      input int ring, input bit selpt, input bit exm, input bit poni, input bit pex, input bit segz);
    bit in_window, reachable;
    int sel;
    in_window = (la >= 16'hFE00);
    reachable = (ring == 3 || !poni || pex) && (!pex || segz);
    if (in_window && reachable) return 7'b100_0000;
    if (!poni) return 7'b010_0000;
    sel = exm ? 0 : (selpt ? apt : pt);
    if (sel >= NUM_PT) return 7'b001_0000;
    return {3'b000, 4'(2 ** sel)};
  endfunction

  // mode 0: normal, 1: CLR_CNT coincident with the DRIVE edge, 2: CSMREQ dropped during CAPT
  task automatic run_req(input logic [15:0] la, input logic [1:0] pt, input logic [1:0] apt,
      input logic [1:0] ring, input bit selpt, input bit exm, input bit poni, input bit pex,
      input bit segz, input int mode);
    logic [6:0] e;
    logic       e_lsh;
    int         ack_at;
    e     = model_decode(la, pt, apt, ring, selpt, exm, poni, pex, segz);
    e_lsh = m_prev_shadow;
    m_prev_shadow = e[6];
    if (mode == 1)                 m_cnt = 0;
    else if (e[6] && m_cnt < 3)    m_cnt = m_cnt + 1;

    @(negedge MCLK);
    bus.LA = la; bus.PCR_PT = pt; bus.PCR_APT = apt; bus.PCR_RING = ring;
    bus.SELPT = selpt; bus.EXM = exm; bus.PONI = poni; bus.PEX = pex; bus.SEGZ = segz;
    bus.CSMREQ = 1'b1;
    ack_at = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge MCLK);
      if (mode == 2 && c == 1) bus.CSMREQ = 1'b0;
      if (mode == 1 && c == 2) bus.CLR_CNT = 1'b1;
      if (mode == 1 && c == 3) bus.CLR_CNT = 1'b0;
      if (bus.ACK) begin ack_at = c; break; end
    end
    n_chk++;
    if (ack_at !== 3) begin
      n_fail++;
      $display("FAIL ack_latency: got cycle %0d, want 3 (la=%h)", ack_at, la);
    end
    n_chk++;
    if ({bus.SHADOW, bus.PHYS, bus.PTERR, bus.PT_SEL} !== e) begin
      n_fail++;
      $display("FAIL decode: got %b, want %b (la=%h pt=%0d apt=%0d ring=%0d sel=%b exm=%b poni=%b pex=%b segz=%b)",
               {bus.SHADOW, bus.PHYS, bus.PTERR, bus.PT_SEL}, e, la, pt, apt, ring, selpt, exm, poni, pex, segz);
    end
    n_chk++;
    if (bus.LSHADOW !== e_lsh || int'(bus.SHCNT) != m_cnt) begin
      n_fail++;
      $display("FAIL lshadow_cnt: got lsh=%b cnt=%0d, want lsh=%b cnt=%0d", bus.LSHADOW, bus.SHCNT, e_lsh, m_cnt);
    end
    n_chk++;
    if (bus.BUSY !== (mode != 2)) begin
      n_fail++;
      $display("FAIL busy_at_ack: got %b, want %b (mode %0d)", bus.BUSY, (mode != 2), mode);
    end
    bus.CSMREQ = 1'b0;
    @(negedge MCLK);
    n_chk++;
    if (bus.ACK !== 1'b0 || bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_pulse_idle: got ack=%b busy=%b, want ack=0 busy=0", bus.ACK, bus.BUSY);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.CSMREQ = 0; bus.LA = 0; bus.PCR_PT = 0; bus.PCR_APT = 0; bus.PCR_RING = 0;
    bus.SELPT = 0; bus.EXM = 0; bus.PONI = 0; bus.PEX = 0; bus.SEGZ = 0; bus.CLR_CNT = 0;
    repeat (2) @(negedge MCLK);
    RESET = 1'b0;
    @(negedge MCLK);
    n_chk++;
    if ({bus.ACK, bus.BUSY, bus.SHADOW, bus.LSHADOW, bus.PHYS, bus.PTERR} !== 6'b0 ||
        bus.PT_SEL !== 4'b0 || bus.SHCNT !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ack=%b busy=%b sh=%b lsh=%b phys=%b pterr=%b sel=%b cnt=%0d, want all 0",
               bus.ACK, bus.BUSY, bus.SHADOW, bus.LSHADOW, bus.PHYS, bus.PTERR, bus.PT_SEL, bus.SHCNT);
    end
    m_prev_shadow = 1'b0;
    m_cnt = 0;
  endtask

  task automatic test_normal_pt();
    run_req(16'h1234, 2'd0, 2'd2, 2'd0, 1, 0, 1, 0, 0, 0);
    n_chk++;
    if (bus.PT_SEL !== 4'b0100 || bus.SHADOW !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_pt: got sel=%b sh=%b, want sel=0100 sh=0", bus.PT_SEL, bus.SHADOW);
    end
  endtask

  task automatic test_shadow();
    run_req(16'hFE10, 2'd1, 2'd1, 2'd3, 0, 0, 1, 0, 0, 0);
    n_chk++;
    if (bus.SHADOW !== 1'b1 || bus.PT_SEL !== 4'b0 || bus.SHCNT !== 2'd1) begin
      n_fail++;
      $display("FAIL shadow_hit: got sh=%b sel=%b cnt=%0d, want sh=1 sel=0000 cnt=1", bus.SHADOW, bus.PT_SEL, bus.SHCNT);
    end
    run_req(16'h0100, 2'd1, 2'd1, 2'd3, 0, 0, 1, 0, 0, 0);
    n_chk++;
    if (bus.LSHADOW !== 1'b1 || bus.SHADOW !== 1'b0) begin
      n_fail++;
      $display("FAIL shadow_lshadow: got lsh=%b sh=%b, want lsh=1 sh=0", bus.LSHADOW, bus.SHADOW);
    end
  endtask

  task automatic test_phys_exm();
    run_req(16'h4000, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (bus.PHYS !== 1'b1 || bus.PT_SEL !== 4'b0) begin
      n_fail++;
      $display("FAIL phys: got phys=%b sel=%b, want phys=1 sel=0000", bus.PHYS, bus.PT_SEL);
    end
    run_req(16'h4000, 2'd3, 2'd2, 2'd0, 0, 1, 1, 0, 0, 0);
    n_chk++;
    if (bus.PT_SEL !== 4'b0001 || bus.PHYS !== 1'b0) begin
      n_fail++;
      $display("FAIL exm: got sel=%b phys=%b, want sel=0001 phys=0", bus.PT_SEL, bus.PHYS);
    end
  endtask

  task automatic test_sat_clear();
    @(negedge MCLK); bus.CLR_CNT = 1'b1;
    @(negedge MCLK); bus.CLR_CNT = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 4; i++) run_req(16'hFF00, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (bus.SHCNT !== 2'd3) begin
      n_fail++;
      $display("FAIL saturate: got cnt=%0d, want 3", bus.SHCNT);
    end
    run_req(16'hFF00, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1);
    n_chk++;
    if (bus.SHCNT !== 2'd0) begin
      n_fail++;
      $display("FAIL clear_wins: got cnt=%0d, want 0", bus.SHCNT);
    end
  endtask

  task automatic test_abort();
    run_req(16'h2000, 2'd1, 2'd0, 2'd0, 0, 0, 1, 0, 0, 2);
    repeat (3) @(negedge MCLK);
    n_chk++;
    if (bus.ACK !== 1'b0 || bus.BUSY !== 1'b0 || bus.PT_SEL !== 4'b0010) begin
      n_fail++;
      $display("FAIL abort_single_ack: got ack=%b busy=%b sel=%b, want ack=0 busy=0 sel=0010", bus.ACK, bus.BUSY, bus.PT_SEL);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [15:0] la;
      la = 16'($urandom);
      if ($urandom_range(0, 1) == 1) la = la | 16'hFE00;
      run_req(la, 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0) ? 1 : 0);
    end
  endtask

  task automatic test_reset_in_drive();
    run_req(16'hFE20, 2'd0, 2'd0, 2'd3, 0, 0, 1, 0, 0, 0);
    @(negedge MCLK);
    bus.LA = 16'h0010; bus.PONI = 1; bus.SELPT = 0; bus.EXM = 0; bus.PCR_PT = 2'd3;
    bus.CSMREQ = 1'b1;
    repeat (2) @(negedge MCLK);
    RESET = 1'b1;
    @(negedge MCLK);
    n_chk++;
    if (bus.ACK !== 1'b0 || bus.BUSY !== 1'b0 || bus.PT_SEL !== 4'b0 || bus.SHADOW !== 1'b0 ||
        bus.LSHADOW !== 1'b0 || bus.SHCNT !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_in_drive: got ack=%b busy=%b sel=%b sh=%b lsh=%b cnt=%0d, want all 0",
               bus.ACK, bus.BUSY, bus.PT_SEL, bus.SHADOW, bus.LSHADOW, bus.SHCNT);
    end
    RESET = 1'b0;
    bus.CSMREQ = 1'b0;
    m_prev_shadow = 1'b0;
    m_cnt = 0;
    run_req(16'h0010, 2'd3, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_normal_pt();
    test_shadow();
    test_phys_exm();
    test_sat_clear();
    test_abort();
    test_random();
    test_reset_in_drive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
